// File: rtl/kernel_pkg.sv
// Shared types and coefficient ROM image for the kernel coefficient loader.
// Define KERNEL_NORM_EN to load word 9 as the normalisation shift.
package kernel_pkg;

    localparam int COEFF_W = 8;
    localparam int KWORDS  = 16;

`ifdef KERNEL_NORM_EN
    localparam int N_WORDS = 10;
`else
    localparam int N_WORDS = 9;
`endif

    typedef logic signed [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_FRAME
    } state_t;

    typedef logic [KWORDS-1:0][COEFF_W-1:0] kword_t;
    typedef kword_t [7:0] rom_t;

    // Words 0..8 row-major coefficients, word 9 shift, 10..15 unused.
    function automatic kword_t kw(
        input int c0, input int c1, input int c2,
        input int c3, input int c4, input int c5,
        input int c6, input int c7, input int c8,
        input int s
    );
        kword_t w;
        w    = '0;
        w[0] = COEFF_W'(c0);
        w[1] = COEFF_W'(c1);
        w[2] = COEFF_W'(c2);
        w[3] = COEFF_W'(c3);
        w[4] = COEFF_W'(c4);
        w[5] = COEFF_W'(c5);
        w[6] = COEFF_W'(c6);
        w[7] = COEFF_W'(c7);
        w[8] = COEFF_W'(c8);
        w[9] = COEFF_W'(s);
        return w;
    endfunction

    function automatic kword_t kern(input logic [2:0] k);
        kword_t w;
        case (k)
            3'd0:    w = kw( 0,  0,  0,  0,  1,  0,  0,  0,  0, 0);
            3'd1:    w = kw( 1,  1,  1,  1,  1,  1,  1,  1,  1, 3);
            3'd2:    w = kw( 0, -1,  0, -1,  4, -1,  0, -1,  0, 0);
            3'd3:    w = kw( 0, -1,  0, -1,  5, -1,  0, -1,  0, 0);
            3'd4:    w = kw( 1,  2,  1,  2,  4,  2,  1,  2,  1, 4);
            3'd5:    w = kw(-1,  0,  1, -2,  0,  2, -1,  0,  1, 0);
            3'd6:    w = kw(-1, -2, -1,  0,  0,  0,  1,  2,  1, 0);
            default: w = kw(-2, -1,  0, -1,  1,  1,  0,  1,  2, 0);
        endcase
        return w;
    endfunction

    localparam rom_t KERNEL_ROM = {
        kern(3'd7), kern(3'd6), kern(3'd5), kern(3'd4),
        kern(3'd3), kern(3'd2), kern(3'd1), kern(3'd0)
    };

endpackage

// File: rtl/kernel_rom.sv
// Registered-read coefficient ROM, address {kernel, word}.
// Kernels beyond N_KERNELS read as zero.
module kernel_rom
    import kernel_pkg::*;
#(
    parameter int N_KERNELS = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_en,
    input  logic [6:0] i_addr,
    output coeff_t     o_data
);

    logic in_range;

    assign in_range = {29'd0, i_addr[6:4]} < N_KERNELS;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= in_range
                ? coeff_t'(KERNEL_ROM[i_addr[6:4]][i_addr[3:0]])
                : '0;
        end
    end

endmodule

// File: rtl/kernel_coeff_loader.sv
// Streams a 3x3 kernel from ROM into a shadow bank, swaps it in on a frame boundary.
// Define KERNEL_NORM_EN to also load and swap the normalisation shift.
module kernel_coeff_loader
    import kernel_pkg::*;
#(
    parameter int COEFF_W   = kernel_pkg::COEFF_W,
    parameter int N_KERNELS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [2:0]           i_address,
    input  logic                 i_frame_start,
    output logic [9*COEFF_W-1:0] o_coeff,
    output logic [3:0]           o_shift,
    output logic [2:0]           o_kernel_id,
    output logic                 o_valid,
    output logic                 o_busy
);

    localparam logic [3:0] LAST = 4'(N_WORDS);

    state_t state;
    state_t state_nx;

    logic [2:0]           target;
    logic [3:0]           idx;
    logic                 load_start;
    logic                 swap;
    logic                 rom_en;
    logic [6:0]           rom_addr;
    coeff_t               rom_data;
    logic [COEFF_W-1:0]   shadow [0:8];
    logic [9*COEFF_W-1:0] coeff_q;
    logic [2:0]           kid_q;
    logic                 valid_q;
    logic                 wr_en;

    kernel_rom #(
        .N_KERNELS(N_KERNELS)
    ) u_rom (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_en     (rom_en),
        .i_addr   (rom_addr),
        .o_data   (rom_data)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_start = 1'b0;
        swap       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!valid_q || i_address != kid_q) begin
                    load_start = 1'b1;
                    state_nx   = LOAD;
                end
            end
            LOAD: begin
                if (i_address != target) begin
                    load_start = 1'b1;
                end else if (idx == LAST) begin
                    state_nx = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                // Swap wins over a same-cycle address change.
                if (i_frame_start) begin
                    swap     = 1'b1;
                    state_nx = IDLE;
                end else if (i_address != target) begin
                    load_start = 1'b1;
                    state_nx   = LOAD;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state != IDLE);
        rom_en   = (state == LOAD) && (idx < LAST);
        rom_addr = {target, idx};
        wr_en    = (state == LOAD) && !load_start && (idx != 4'd0);
    end

    // Word idx-1 returns from ROM while idx is presented.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            target <= '0;
            idx    <= '0;
            for (int i = 0; i < 9; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (load_start) begin
                target <= i_address;
                idx    <= '0;
            end else if (state == LOAD && idx != LAST) begin
                idx <= idx + 4'd1;
            end
            for (int i = 0; i < 9; i++) begin
                if (wr_en && idx == 4'(i + 1)) begin
                    shadow[i] <= COEFF_W'(rom_data);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            coeff_q <= '0;
            kid_q   <= '0;
            valid_q <= 1'b0;
        end else if (swap) begin
            for (int i = 0; i < 9; i++) begin
                coeff_q[i*COEFF_W +: COEFF_W] <= shadow[i];
            end
            kid_q   <= target;
            valid_q <= 1'b1;
        end
    end

`ifdef KERNEL_NORM_EN
    logic [3:0] shadow_shift;
    logic [3:0] shift_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shadow_shift <= '0;
            shift_q      <= '0;
        end else begin
            if (wr_en && idx == 4'd10) begin
                shadow_shift <= rom_data[3:0];
            end
            if (swap) begin
                shift_q <= shadow_shift;
            end
        end
    end

    assign o_shift = shift_q;
`else
    assign o_shift = 4'd0;
`endif

    assign o_coeff     = coeff_q;
    assign o_kernel_id = kid_q;
    assign o_valid     = valid_q;

endmodule
